// File: rtl/noc_arb_pkg.sv
// rtl/noc_arb_pkg.sv - shared types and header helpers for the NoC injection arbiter
package noc_arb_pkg;

  typedef enum logic {IDLE, PKT} arb_state_t;

  localparam int NOC_LEN_W = 8;

  // Payload length field of a header flit (body flits that follow it)
  function automatic logic [NOC_LEN_W-1:0] hdr_len(input logic [511:0] flit, input int lsb);
    return flit[lsb +: NOC_LEN_W];
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// rtl/noc_inject_arbiter_if.sv - source-side and link-side handshake bundle
interface noc_inject_arbiter_if #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 64
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic                   out_yummy;

  modport master (
    output req_valid, req_data, out_yummy,
    input  req_ready, out_valid, out_data
  );

  modport slave (
    input  req_valid, req_data, out_yummy,
    output req_ready, out_valid, out_data
  );
endinterface

// File: rtl/noc_inject_arbiter_rr_pick.sv
// rtl/noc_inject_arbiter_rr_pick.sv - combinational round-robin picker starting at rr_ptr
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);
  int j;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    j        = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        pick_idx = IDX_W'(j);
        pick[j]  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - packet-granular round-robin injection onto a credit-based NoC link
// Optional per-source completed-packet counters on pkt_count when NOC_ARB_STATS_EN is defined.
module noc_inject_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int DATA_W  = 64,
  parameter int CREDITS = 4,
  parameter int LEN_LSB = 22,
  parameter int IDX_W   = $clog2(NREQ),
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  noc_inject_arbiter_if.slave bus,
  output logic [IDX_W-1:0]  grant_idx,
  output logic [CW-1:0]     credit_cnt
`ifdef NOC_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] pkt_count
`endif
);
  arb_state_t           state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_nxt, grant_nxt;
  logic [NOC_LEN_W-1:0] remaining, rem_nxt, len;
  logic [NREQ-1:0]      pick_onehot, ready;
  logic [IDX_W-1:0]     pick_idx, sel_idx;
  logic                 pick_any, xfer, last;
  logic [DATA_W-1:0]    sel_data;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req      (bus.req_valid),
    .rr_ptr   (rr_ptr),
    .pick     (pick_onehot),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign sel_idx  = (state == PKT) ? grant_idx : pick_idx;
  assign sel_data = bus.req_data[int'(sel_idx)*DATA_W +: DATA_W];
  assign len      = hdr_len(512'(sel_data), LEN_LSB);
  assign xfer     = |(bus.req_valid & ready);
  assign last     = (state == IDLE) ? (len == '0) : (remaining == NOC_LEN_W'(1));

  // Ready is gated by reset so the link looks quiet while sources are still held in reset
  always_comb begin
    ready = '0;
    if (reset_n && credit_cnt != '0) begin
      if (state == PKT)  ready[grant_idx] = 1'b1;
      else if (pick_any) ready = pick_onehot;
    end
  end
  assign bus.req_ready = ready;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant_nxt = grant_idx;
    rem_nxt   = remaining;
    if (xfer) begin
      case (state)
        IDLE: begin
          grant_nxt = pick_idx;
          if (len == '0) begin
            rr_nxt = idx_inc(pick_idx);
          end else begin
            state_nxt = PKT;
            rem_nxt   = len;
          end
        end
        PKT: begin
          rem_nxt = remaining - 1'b1;
          if (remaining == NOC_LEN_W'(1)) begin
            state_nxt = IDLE;
            rr_nxt    = idx_inc(grant_idx);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      grant_idx <= grant_nxt;
      remaining <= rem_nxt;
    end
  end

  // A transfer and a yummy in the same cycle cancel out
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credit_cnt <= CW'(CREDITS);
    end else begin
      case ({xfer, bus.out_yummy})
        2'b10:   credit_cnt <= credit_cnt - 1'b1;
        2'b01:   if (credit_cnt != CW'(CREDITS)) credit_cnt <= credit_cnt + 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= xfer;
      if (xfer) bus.out_data <= sel_data;
    end
  end

  yummy_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(bus.out_yummy && credit_cnt == CW'(CREDITS)));

`ifdef NOC_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else if (xfer && last) begin
      pkt_count[int'(sel_idx)*16 +: 16] <= pkt_count[int'(sel_idx)*16 +: 16] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb/tb_noc_inject_arbiter.sv - directed self-checking bench for noc_inject_arbiter
module tb_noc_inject_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 64;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  noc_inject_arbiter_if #(.NREQ(NREQ), .DATA_W(DW)) bus ();
  logic [1:0] grant_idx;
  logic [2:0] credit_cnt;
`ifdef NOC_ARB_STATS_EN
  logic [NREQ*16-1:0] pkt_count;
`endif

  noc_inject_arbiter #(.NREQ(NREQ), .DATA_W(DW), .CREDITS(4), .LEN_LSB(22)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .grant_idx  (grant_idx),
    .credit_cnt (credit_cnt)
`ifdef NOC_ARB_STATS_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] q2[$];
  logic       man_yummy = 1'b0;
  logic [1:0] ymode = 2'd0;
  logic [1:0] vhist;

  // Downstream model: yummy off, same cycle as out_valid, or two cycles later
  always @(posedge clock or negedge reset_n)
    if (!reset_n) vhist <= 2'b00;
    else          vhist <= {vhist[0], bus.out_valid};
  assign bus.out_yummy = man_yummy | (ymode == 2'd1 && bus.out_valid) | (ymode == 2'd2 && vhist[1]);

  function automatic logic [63:0] hdr(input int src, input int len, input int tag);
    return 64'hA000_0000_0000_0000 | (64'(src) << 40) | (64'(tag) << 32) | (64'(len) << 22);
  endfunction

  function automatic logic [63:0] body(input int src, input int k);
    return 64'hB000_0000_0000_0000 | (64'(src) << 40) | 64'(k + 1);
  endfunction

  task automatic drive_srcs();
    bus.req_valid = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
    bus.req_data  = {(q2.size() != 0) ? q2[0] : 64'd0,
                     (q1.size() != 0) ? q1[0] : 64'd0,
                     (q0.size() != 0) ? q0[0] : 64'd0};
  endtask

  task automatic step();
    logic [2:0] take;
    @(negedge clock);
    take = bus.req_valid & bus.req_ready;
    @(posedge clock);
    #1;
    if (take[0]) void'(q0.pop_front());
    if (take[1]) void'(q1.pop_front());
    if (take[2]) void'(q2.pop_front());
    drive_srcs();
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    ymode     = 2'd0;
    man_yummy = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    drive_srcs();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    n_cmp++; if (credit_cnt !== 3'd4) begin n_bad++; $display("FAIL reset_credit: got %0d want 4", credit_cnt); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.req_ready !== 3'b000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 000", bus.req_ready); end
    n_cmp++; if (bus.out_data !== 64'd0) begin n_bad++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_cmp++; if (grant_idx !== 2'd0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", grant_idx); end
    bad = 0;
    repeat (20) begin
      step();
      if (bus.out_valid !== 1'b0 || credit_cnt !== 3'd4 || bus.req_ready !== 3'b000) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL idle_quiet: got %0d noisy cycles want 0", bad); end
  endtask

  task automatic test_single_packet();
    do_reset();
    ymode = 2'd2;
    q1.push_back(hdr(1, 2, 1)); q1.push_back(body(1, 0)); q1.push_back(body(1, 1));
    drive_srcs(); #1;
    n_cmp++; if (bus.req_ready !== 3'b010) begin n_bad++; $display("FAIL sp_ready: got %b want 010", bus.req_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== hdr(1, 2, 1)) begin n_bad++; $display("FAIL sp_hdr: got %b/%h want 1/%h", bus.out_valid, bus.out_data, hdr(1, 2, 1)); end
    n_cmp++; if (credit_cnt !== 3'd3 || grant_idx !== 2'd1) begin n_bad++; $display("FAIL sp_credit_grant: got %0d/%0d want 3/1", credit_cnt, grant_idx); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== body(1, 0)) begin n_bad++; $display("FAIL sp_body0: got %b/%h want 1/%h", bus.out_valid, bus.out_data, body(1, 0)); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== body(1, 1)) begin n_bad++; $display("FAIL sp_body1: got %b/%h want 1/%h", bus.out_valid, bus.out_data, body(1, 1)); end
    n_cmp++; if (credit_cnt !== 3'd1) begin n_bad++; $display("FAIL sp_credit_low: got %0d want 1", credit_cnt); end
    repeat (3) step();
    n_cmp++; if (credit_cnt !== 3'd4 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL sp_credit_back: got %0d/%b want 4/0", credit_cnt, bus.out_valid); end
    q0.push_back(hdr(0, 0, 7)); q2.push_back(hdr(2, 0, 8));
    drive_srcs(); #1;
    n_cmp++; if (bus.req_ready !== 3'b100) begin n_bad++; $display("FAIL sp_rr_ptr: got %b want 100", bus.req_ready); end
    step();
    n_cmp++; if (bus.out_data !== hdr(2, 0, 8)) begin n_bad++; $display("FAIL sp_next_grant: got %h want %h", bus.out_data, hdr(2, 0, 8)); end
  endtask

  task automatic test_round_robin();
    do_reset();
    ymode = 2'd1;
    q0.push_back(hdr(0, 0, 1)); q0.push_back(hdr(0, 0, 4));
    q1.push_back(hdr(1, 0, 2)); q1.push_back(hdr(1, 0, 5));
    q2.push_back(hdr(2, 0, 3)); q2.push_back(hdr(2, 0, 6));
    drive_srcs(); #1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== hdr(k % 3, 0, k + 1)) begin
        n_bad++; $display("FAIL rr_flit%0d: got %b/%h want 1/%h", k, bus.out_valid, bus.out_data, hdr(k % 3, 0, k + 1));
      end
    end
    n_cmp++; if (credit_cnt !== 3'd3) begin n_bad++; $display("FAIL rr_credit: got %0d want 3", credit_cnt); end
`ifdef NOC_ARB_STATS_EN
    n_cmp++; if (pkt_count !== {16'd2, 16'd2, 16'd2}) begin n_bad++; $display("FAIL rr_stats: got %h want 000200020002", pkt_count); end
`endif
    step();
    n_cmp++; if (credit_cnt !== 3'd4 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drain: got %0d/%b want 4/0", credit_cnt, bus.out_valid); end
  endtask

  task automatic test_credit_stall();
    do_reset();
    q0.push_back(hdr(0, 5, 9));
    for (int k = 0; k < 5; k++) q0.push_back(body(0, k));
    drive_srcs(); #1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== ((k == 0) ? hdr(0, 5, 9) : body(0, k - 1))) begin
        n_bad++; $display("FAIL cs_flit%0d: got %b/%h", k, bus.out_valid, bus.out_data);
      end
    end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 3'b000 || credit_cnt !== 3'd0) begin
      n_bad++; $display("FAIL cs_stalled: got %b/%b/%0d want 0/000/0", bus.out_valid, bus.req_ready, credit_cnt);
    end
    man_yummy = 1'b1;
    step();
    man_yummy = 1'b0;
    n_cmp++; if (credit_cnt !== 3'd1 || bus.req_ready !== 3'b001 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL cs_one_credit: got %0d/%b/%b want 1/001/0", credit_cnt, bus.req_ready, bus.out_valid);
    end
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== body(0, 3) || credit_cnt !== 3'd0) begin
      n_bad++; $display("FAIL cs_release: got %b/%h/%0d want 1/%h/0", bus.out_valid, bus.out_data, credit_cnt, body(0, 3));
    end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL cs_only_one: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_pkt_hold();
    do_reset();
    ymode = 2'd1;
    q2.push_back(hdr(2, 3, 10));
    for (int k = 0; k < 3; k++) q2.push_back(body(2, k));
    drive_srcs(); #1;
    step();
    q0.push_back(hdr(0, 0, 11));
    drive_srcs(); #1;
    n_cmp++; if (bus.req_ready !== 3'b100) begin n_bad++; $display("FAIL ph_locked: got %b want 100", bus.req_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (bus.out_data !== body(2, k)) begin n_bad++; $display("FAIL ph_body%0d: got %h want %h", k, bus.out_data, body(2, k)); end
      n_cmp++;
      if (bus.req_ready !== ((k < 2) ? 3'b100 : 3'b001)) begin
        n_bad++; $display("FAIL ph_ready%0d: got %b want %b", k, bus.req_ready, (k < 2) ? 3'b100 : 3'b001);
      end
    end
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== hdr(0, 0, 11) || grant_idx !== 2'd0) begin
      n_bad++; $display("FAIL ph_next: got %b/%h/%0d want 1/%h/0", bus.out_valid, bus.out_data, grant_idx, hdr(0, 0, 11));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    q0.push_back(hdr(0, 5, 12));
    for (int k = 0; k < 5; k++) q0.push_back(body(0, k));
    drive_srcs(); #1;
    repeat (3) step();
    n_cmp++; if (bus.out_data !== body(0, 1) || grant_idx !== 2'd0) begin n_bad++; $display("FAIL rm_pre: got %h/%0d want %h/0", bus.out_data, grant_idx, body(0, 1)); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 || bus.req_ready !== 3'b000 || credit_cnt !== 3'd4 || grant_idx !== 2'd0) begin
      n_bad++; $display("FAIL rm_reset: got %b/%h/%b/%0d/%0d", bus.out_valid, bus.out_data, bus.req_ready, credit_cnt, grant_idx);
    end
`ifdef NOC_ARB_STATS_EN
    n_cmp++; if (pkt_count !== '0) begin n_bad++; $display("FAIL rm_stats_clear: got %h want 0", pkt_count); end
`endif
    q0.delete();
    drive_srcs();
    @(posedge clock); #1;
    reset_n = 1'b1;
    q1.push_back(hdr(1, 0, 13));
    drive_srcs(); #1;
    step();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== hdr(1, 0, 13) || grant_idx !== 2'd1) begin
      n_bad++; $display("FAIL rm_after: got %b/%h/%0d want 1/%h/1", bus.out_valid, bus.out_data, grant_idx, hdr(1, 0, 13));
    end
`ifdef NOC_ARB_STATS_EN
    n_cmp++; if (pkt_count !== {16'd0, 16'd1, 16'd0}) begin n_bad++; $display("FAIL rm_stats: got %h want 000000010000", pkt_count); end
`endif
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_credit_stall();
    test_pkt_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end
endmodule

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
- Shares one OpenPiton-style NoC injection link (valid/data/yummy, credit-based) among NREQ packet sources on the off-chip bridge side.
- Typical use: several bridge-side engines inject into one of the b2c_noc1/2/3 channels toward the chip.
- Round-robin arbitration at packet granularity. A granted source keeps the link until its last flit is sent.
- Flits are forwarded only when downstream credit is available. Credits are returned one per yummy pulse.

Parameters:
- NREQ, 3: number of requesters (2..8).
- DATA_W, 64: flit width; equals NOC_DATA_WIDTH.
- CREDITS, 4: downstream input-buffer depth; the credit counter resets to this value.
- LEN_LSB, 22: LSB of the 8-bit payload-length field in the header flit. The field is hdr[LEN_LSB+7:LEN_LSB] and gives the count of body flits after the header.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-source flit valid.
- req_data  in  NREQ*DATA_W  per-source flit; source i occupies [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  per-source flit accept.
- out_valid  out  1  link flit valid, registered.
- out_data  out  DATA_W  link flit, registered.
- out_yummy  in  1  one-cycle credit return from downstream.
- grant_idx  out  $clog2(NREQ)  index of the current or last granted source (debug).
- credit_cnt  out  $clog2(CREDITS+1)  current credit count (debug).

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, req_ready=0.
  - state=IDLE, rr_ptr=0, grant_idx=0, remaining=0, credit_cnt=CREDITS.
- Transfer rule: a flit moves from source i on the cycle req_valid[i] && req_ready[i] is high.
  - Sources must hold req_valid and req_data stable until the flit is accepted.
  - Within a packet, sources may deassert req_valid between flits (bubbles are allowed).
- Ready generation:
  - req_ready[i] is combinational from registered state: (i == selected source) && credit_cnt != 0.
  - At most one bit is set.
- Latency: the accepted flit appears on out_data with out_valid=1 on the next cycle, for exactly one cycle. out_valid is high in any cycle only if a transfer occurred in the previous cycle.
- States:
  - IDLE: the selected source is the first requester with req_valid set, searching from rr_ptr upward with wrap-around. If no requester is valid, all req_ready are 0.
    - On header transfer with length==0: remain in IDLE, set rr_ptr=winner+1 (mod NREQ), set grant_idx=winner.
    - On header transfer with length>0: go to PKT, set grant_idx=winner, remaining=length.
  - PKT: the selected source is grant_idx; other sources are ignored.
    - Each transfer decrements remaining.
    - A transfer with remaining==1 returns to IDLE and sets rr_ptr=grant_idx+1 (mod NREQ).
- Credits:
  - Transfer only: decrement by 1.
  - out_yummy only: increment by 1.
  - Both in the same cycle: unchanged.
  - At credit_cnt==0 no transfer is possible.
  - A yummy arriving while credit_cnt==CREDITS is a protocol error. The counter saturates at CREDITS and a simulation assertion fires.
- Back-to-back: a new packet header may transfer in the cycle immediately after a packet ends (full link throughput). Single-flit packets from different sources alternate every cycle when credits allow.
- Reset asserted mid-packet: the partial packet is abandoned and all state returns to reset values. Sources reset with the same reset_n.

Optional Feature:
- NOC_ARB_STATS_EN: when defined, adds output pkt_count (NREQ*16).
  - Holds one 16-bit wrapping counter per source, cleared on reset.
  - A counter increments when its source completes a packet (the header of a length-0 packet, or the last body flit).
- When undefined: the port and the counters are absent, and all other behaviour is identical.

Decomposition:
- Package noc_arb_pkg:
  - state enum {IDLE, PKT}.
  - NOC_LEN_W=8.
  - Function hdr_len(flit, lsb) that extracts the length field.
- Sub-module rr_pick:
  - Combinational NREQ-wide round-robin priority picker.
  - Inputs: req vector, rr_ptr. Outputs: one-hot pick, index, any-valid.
- The top holds the FSM, credit counter, output register and optional stats counters.

Test Plan:
- Reset with CREDITS=4, no traffic → credit_cnt=4, out_valid=0, req_ready=0; yummy pulses are absent; idle link stays quiet for 20 cycles.
- Source 1 sends a header with length=2 plus 2 body flits, out_yummy returned 2 cycles after each flit → 3 out_valid pulses in order, data matches, credit_cnt returns to 4, rr_ptr=2.
- Sources 0, 1 and 2 all hold single-flit packets (length=0) continuously with immediate yummy → grant order 0,1,2,0,1,2, one flit per cycle.
- Source 0 sends a length=5 packet with out_yummy held low → exactly 4 flits forwarded, then req_ready=0 and credit_cnt=0. One yummy releases exactly one more flit.
- Source 2 is in PKT with 3 flits remaining while source 0 asserts req_valid → source 0 sees no req_ready until source 2's last flit, then is granted on the next cycle.
- reset_n asserted mid-packet (remaining=3) → all outputs are at reset values immediately; after release, a new length-0 packet from source 1 is forwarded normally. With NOC_ARB_STATS_EN, pkt_count is cleared to 0.
